// File: rtl/param_chan_regbank_if.sv
// Command port for param_chan_regbank: one valid/ready command carrying
// an opcode, a target channel and write data.
interface param_chan_regbank_if #(
    parameter int WIDTH = 2,
    parameter int CW    = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CW-1:0]    cmd_chan;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_chan, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_chan, cmd_data, output cmd_ready);
endinterface

// File: rtl/param_chan_regbank.sv
// Parameter-driven bank of CHANNELS x WIDTH registers with per-bit output
// inversion, a command port (write/incr/decr/restore) and a restore-all sweep
// that reloads one channel per cycle from INIT.
module param_chan_regbank #(
    parameter int                         WIDTH    = 2,
    parameter int                         CHANNELS = 4,
    parameter logic [CHANNELS*WIDTH-1:0]  INIT     = 8'b10_11_00_01,
    parameter logic [CHANNELS*WIDTH-1:0]  INV_MASK = '0,
    localparam int                        CW       = $clog2(CHANNELS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    param_chan_regbank_if.slave         cmd_if,
    input  logic                        i_restore_all,
    output logic                        o_busy,
    output logic                        o_err,
    output logic [CHANNELS*WIDTH-1:0]   o_val,
    input  logic [CW-1:0]               i_rd_chan,
    output logic [WIDTH-1:0]            o_rd_data
);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                          r_state;
    logic [CW-1:0]                   r_idx;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_regs;
    logic [WIDTH-1:0]                r_rd_data;
    logic                            r_err;

    logic [CHANNELS-1:0][WIDTH-1:0]  w_init;
    logic [CHANNELS-1:0][WIDTH-1:0]  w_mask;
    logic                            w_acc;
    logic                            w_in_range;
    logic [WIDTH-1:0]                w_rd;

    // Per-channel views of the flat parameters
    assign w_init = INIT;
    assign w_mask = INV_MASK;

    // A pending restore_all takes priority over a command in the same cycle
    assign cmd_if.cmd_ready = (r_state == S_IDLE) && !i_restore_all;
    assign w_acc            = cmd_if.cmd_valid && cmd_if.cmd_ready;
    // Only meaningful for non-power-of-2 CHANNELS; otherwise always true
    assign w_in_range       = ({1'b0, cmd_if.cmd_chan} < (CW+1)'(CHANNELS));

    assign o_val     = r_regs ^ w_mask;
    assign o_busy    = (r_state == S_SWEEP);
    assign o_err     = r_err;
    assign o_rd_data = r_rd_data;

    // Readback mux; unmatched (out-of-range) select yields zero
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_rd_chan == CW'(k)) w_rd = r_regs[k] ^ w_mask[k];
        end
    end

    // Sweep FSM: IDLE until restore_all, then walk idx 0..CHANNELS-1 once
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_restore_all) begin
                        r_state <= S_SWEEP;
                        r_idx   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (r_idx == CW'(CHANNELS - 1)) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register bank: sweep reload has priority; otherwise apply accepted command
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= w_init;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (r_state == S_SWEEP) begin
                    if (r_idx == CW'(k)) r_regs[k] <= w_init[k];
                end else if (w_acc && w_in_range && (cmd_if.cmd_chan == CW'(k))) begin
                    case (cmd_if.cmd_op)
                        2'b00:   r_regs[k] <= cmd_if.cmd_data;
                        2'b01:   r_regs[k] <= r_regs[k] + WIDTH'(1);
                        2'b10:   r_regs[k] <= r_regs[k] - WIDTH'(1);
                        default: r_regs[k] <= w_init[k];
                    endcase
                end
            end
        end
    end

    // Registered readback (pre-update value) and out-of-range error pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rd_data <= w_rd;
            r_err     <= w_acc && !w_in_range;
        end
    end

endmodule

// File: tb/tb_param_chan_regbank.sv
// Bench for param_chan_regbank: three instances (default, inverted mask,
// 3 channels) driven sequentially; expectations queued at stimulus time and
// compared at the following negedge.
module tb_param_chan_regbank;

    localparam int O_VAL = 0, O_RD = 1, O_BUSY = 2, O_RDY = 3, O_ERR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       c_valid [3];
    logic [1:0] c_op    [3];
    logic [1:0] c_chan  [3];
    logic [1:0] c_data  [3];
    logic       restore [3];
    logic [1:0] rd_chan [3];

    logic [7:0] val0, val1;
    logic [5:0] val2;
    logic [1:0] rd0, rd1, rd2;
    logic       busy0, busy1, busy2, err0, err1, err2;

    logic [7:0] val_w  [3];
    logic [1:0] rd_w   [3];
    logic       busy_w [3];
    logic       err_w  [3];
    logic       rdy_w  [3];

    param_chan_regbank_if #(.WIDTH(2), .CW(2)) u_if0 (), u_if1 (), u_if2 ();

    assign u_if0.cmd_valid = c_valid[0]; assign u_if0.cmd_op = c_op[0];
    assign u_if0.cmd_chan  = c_chan[0];  assign u_if0.cmd_data = c_data[0];
    assign u_if1.cmd_valid = c_valid[1]; assign u_if1.cmd_op = c_op[1];
    assign u_if1.cmd_chan  = c_chan[1];  assign u_if1.cmd_data = c_data[1];
    assign u_if2.cmd_valid = c_valid[2]; assign u_if2.cmd_op = c_op[2];
    assign u_if2.cmd_chan  = c_chan[2];  assign u_if2.cmd_data = c_data[2];

    param_chan_regbank u_dut0 (
        .i_clk(clk), .i_rst(rst), .cmd_if(u_if0.slave), .i_restore_all(restore[0]),
        .o_busy(busy0), .o_err(err0), .o_val(val0), .i_rd_chan(rd_chan[0]), .o_rd_data(rd0)
    );

    param_chan_regbank #(.INV_MASK(8'hFF)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .cmd_if(u_if1.slave), .i_restore_all(restore[1]),
        .o_busy(busy1), .o_err(err1), .o_val(val1), .i_rd_chan(rd_chan[1]), .o_rd_data(rd1)
    );

    param_chan_regbank #(.CHANNELS(3), .INIT(6'b11_10_01)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .cmd_if(u_if2.slave), .i_restore_all(restore[2]),
        .o_busy(busy2), .o_err(err2), .o_val(val2), .i_rd_chan(rd_chan[2]), .o_rd_data(rd2)
    );

    assign val_w[0] = val0;  assign val_w[1] = val1;  assign val_w[2] = {2'b00, val2};
    assign rd_w[0]  = rd0;   assign rd_w[1]  = rd1;   assign rd_w[2]  = rd2;
    assign busy_w[0] = busy0; assign busy_w[1] = busy1; assign busy_w[2] = busy2;
    assign err_w[0]  = err0;  assign err_w[1]  = err1;  assign err_w[2]  = err2;
    assign rdy_w[0]  = u_if0.cmd_ready;
    assign rdy_w[1]  = u_if1.cmd_ready;
    assign rdy_w[2]  = u_if2.cmd_ready;

    // Reference model of the register contents
    logic [1:0] m      [3][4];
    int         nch    [3] = '{4, 4, 3};
    logic [7:0] init_v [3] = '{8'hB1, 8'hB1, 8'h39};
    logic [7:0] mask_v [3] = '{8'h00, 8'hFF, 8'h00};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          code;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int code(input int d, input int s);
        return d * 8 + s;
    endfunction

    function automatic logic [31:0] obs(input int c);
        int d = c / 8;
        int s = c % 8;
        logic [31:0] r = '0;
        case (s)
            O_VAL:  r = 32'(val_w[d]);
            O_RD:   r = 32'(rd_w[d]);
            O_BUSY: r = 32'(busy_w[d]);
            O_RDY:  r = 32'(rdy_w[d]);
            O_ERR:  r = 32'(err_w[d]);
            default: r = 32'hDEAD;
        endcase
        return r;
    endfunction

    task automatic expect_(input string tag, input int d, input int s, input logic [31:0] e);
        sb_t x;
        x.tag = tag; x.code = code(d, s); x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        sb_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk(x.tag, obs(x.code), x.exp);
        end
    endtask

    task automatic m_reset();
        logic [7:0] iv;
        for (int d = 0; d < 3; d++) begin
            iv = init_v[d];
            for (int k = 0; k < 4; k++) m[d][k] = iv[k*2 +: 2];
        end
    endtask

    task automatic m_apply(input int d, input logic [1:0] op, input logic [1:0] ch, input logic [1:0] dat);
        logic [7:0] iv;
        iv = init_v[d];
        if (int'(ch) >= nch[d]) return;
        case (op)
            2'b00: m[d][ch] = dat;
            2'b01: m[d][ch] = m[d][ch] + 2'd1;
            2'b10: m[d][ch] = m[d][ch] - 2'd1;
            default: m[d][ch] = iv[ch*2 +: 2];
        endcase
    endtask

    function automatic logic [31:0] pack(input int d);
        logic [7:0] v  = '0;
        logic [7:0] mk = mask_v[d];
        for (int k = 0; k < nch[d]; k++) v[k*2 +: 2] = m[d][k] ^ mk[k*2 +: 2];
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command, wait (bounded) for acceptance, release after the accepting edge
    task automatic cmd(input int d, input logic [1:0] op, input logic [1:0] ch, input logic [1:0] dat);
        int n = 0;
        step();
        c_valid[d] = 1'b1; c_op[d] = op; c_chan[d] = ch; c_data[d] = dat;
        @(negedge clk);
        while (!rdy_w[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 32'(rdy_w[d]), 32'd1);
        step();
        c_valid[d] = 1'b0;
        m_apply(d, op, ch, dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            c_valid[d] = 1'b0; c_op[d] = 2'b00; c_chan[d] = 2'b00; c_data[d] = 2'b00;
            restore[d] = 1'b0;
        end
        rd_chan[0] = 2'd2; rd_chan[1] = 2'd0; rd_chan[2] = 2'd1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of all three instances
        expect_("rst_val0", 0, O_VAL, 32'hB1);
        expect_("rst_busy0", 0, O_BUSY, 32'd0);
        expect_("rst_rd0", 0, O_RD, 32'd0);
        expect_("rst_err0", 0, O_ERR, 32'd0);
        expect_("rst_rdy0", 0, O_RDY, 32'd1);
        expect_("rst_val1", 1, O_VAL, 32'h4E);
        expect_("rst_val2", 2, O_VAL, 32'h39);
        @(negedge clk); drain();
        expect_("rd0_ch2", 0, O_RD, 32'h3);
        expect_("rd1_ch0", 1, O_RD, 32'h2);
        expect_("rd2_ch1", 2, O_RD, 32'h2);
        @(negedge clk); drain();

        // incr wrap, decr wrap, write
        cmd(0, 2'b01, 2'd2, 2'b00);
        expect_("incr_wrap", 0, O_VAL, 32'h81);
        @(negedge clk); drain();
        cmd(0, 2'b10, 2'd1, 2'b00);
        expect_("decr_wrap", 0, O_VAL, pack(0));
        @(negedge clk); drain();
        cmd(0, 2'b00, 2'd0, 2'b10);
        expect_("write_ch0", 0, O_VAL, 32'h8E);
        @(negedge clk); drain();

        // Readback sampled at the writing edge returns the old value
        rd_chan[0] = 2'd3;
        cmd(0, 2'b00, 2'd3, 2'b01);
        expect_("rd_pre_upd", 0, O_RD, 32'h2);
        expect_("val_post_upd", 0, O_VAL, pack(0));
        @(negedge clk); drain();
        expect_("rd_post_upd", 0, O_RD, 32'h1);
        @(negedge clk); drain();

        // Restore-all sweep with a colliding command
        for (int k = 0; k < 4; k++) cmd(0, 2'b00, 2'(k), 2'b01);
        expect_("all_01", 0, O_VAL, 32'h55);
        @(negedge clk); drain();
        step();
        restore[0] = 1'b1;
        c_valid[0] = 1'b1; c_op[0] = 2'b00; c_chan[0] = 2'd2; c_data[0] = 2'b00;
        expect_("ra_rdy_low", 0, O_RDY, 32'd0);
        expect_("ra_busy_pre", 0, O_BUSY, 32'd0);
        @(negedge clk); drain();
        step();
        restore[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) restore[0] = 1'b1;
            expect_("sweep_busy", 0, O_BUSY, 32'd1);
            expect_("sweep_rdy", 0, O_RDY, 32'd0);
            expect_("sweep_val", 0, O_VAL, pack(0));
            @(negedge clk); drain();
            step();
            restore[0] = 1'b0;
            m_apply(0, 2'b11, 2'(i), 2'b00);
        end
        expect_("sweep_done_busy", 0, O_BUSY, 32'd0);
        expect_("sweep_done_rdy", 0, O_RDY, 32'd1);
        expect_("sweep_done_val", 0, O_VAL, 32'hB1);
        @(negedge clk); drain();
        step();
        c_valid[0] = 1'b0;
        m_apply(0, 2'b00, 2'd2, 2'b00);
        expect_("pending_cmd", 0, O_VAL, 32'h81);
        @(negedge clk); drain();

        // Single-channel restore
        cmd(0, 2'b11, 2'd2, 2'b00);
        expect_("restore_ch2", 0, O_VAL, 32'hB1);
        @(negedge clk); drain();

        // Inverted mask
        cmd(1, 2'b01, 2'd0, 2'b00);
        expect_("mask_incr", 1, O_VAL, 32'h4D);
        @(negedge clk); drain();
        cmd(1, 2'b10, 2'd1, 2'b00);
        expect_("mask_decr", 1, O_VAL, pack(1));
        @(negedge clk); drain();

        // Three channels: out-of-range command and readback
        cmd(2, 2'b00, 2'd3, 2'b00);
        expect_("oor_err", 2, O_ERR, 32'd1);
        expect_("oor_val", 2, O_VAL, 32'h39);
        @(negedge clk); drain();
        rd_chan[2] = 2'd3;
        expect_("oor_err_pulse", 2, O_ERR, 32'd0);
        expect_("oor_rd", 2, O_RD, 32'd0);
        @(negedge clk); drain();
        cmd(2, 2'b01, 2'd2, 2'b00);
        expect_("c3_incr_wrap", 2, O_VAL, 32'h09);
        expect_("c3_no_err", 2, O_ERR, 32'd0);
        @(negedge clk); drain();

        // Reset in the middle of a sweep
        for (int k = 0; k < 4; k++) cmd(0, 2'b00, 2'(k), 2'b10);
        expect_("all_10", 0, O_VAL, 32'hAA);
        @(negedge clk); drain();
        step();
        restore[0] = 1'b1;
        step();
        restore[0] = 1'b0;
        step();
        m_apply(0, 2'b11, 2'd0, 2'b00);
        rst = 1'b1;
        expect_("mid_busy", 0, O_BUSY, 32'd1);
        expect_("mid_val", 0, O_VAL, 32'hA9);
        @(negedge clk); drain();
        step();
        rst = 1'b0;
        m_reset();
        expect_("abort_val0", 0, O_VAL, 32'hB1);
        expect_("abort_busy", 0, O_BUSY, 32'd0);
        expect_("abort_rdy", 0, O_RDY, 32'd1);
        expect_("abort_rd", 0, O_RD, 32'd0);
        expect_("abort_val1", 1, O_VAL, 32'h4E);
        expect_("abort_val2", 2, O_VAL, 32'h39);
        @(negedge clk); drain();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_("idle_busy", 0, O_BUSY, 32'd0);
            expect_("idle_rd", 0, O_RD, 32'h2);
            @(negedge clk); drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
